// File: rtl/rc5_key_loader.sv
// RC5 key byte-to-word loader: streams K[b-1..0] from a synchronous key RAM and
// writes the packed words L[c-1..0] to the L RAM, highest address first.
module rc5_key_loader #(
   parameter int W     = 32,
   parameter int B_LEN = 8,
   parameter int C_LEN = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [B_LEN-1:0] key_len,
   output logic [B_LEN-1:0] key_addr,
   input  logic [7:0]       key_byte,
   output logic             L_we,
   output logic [C_LEN-1:0] L_addr,
   output logic [W-1:0]     L_data,
   output logic             busy,
   output logic             done,
   output logic [2:0]       o_dbg_state
);

   localparam int               U_LG     = $clog2(W / 8);
   localparam logic [B_LEN-1:0] LOW_MASK = B_LEN'((W / 8) - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ZERO   = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_FIN    = 3'd4
   } state_t;

   state_t             r_state;
   logic [B_LEN-1:0]   r_key_addr;
   logic [B_LEN-1:0]   r_j;
   logic               r_valid;
   logic [W-1:0]       r_acc;
   logic               r_L_we;
   logic [C_LEN-1:0]   r_L_addr;
   logic [W-1:0]       r_L_data;
   logic               r_busy;
   logic               r_done;

   logic [W-1:0]       w_acc_next;
   logic               w_word_end;
   logic [C_LEN-1:0]   w_word_idx;

   // The byte arriving now belongs to index r_j, issued one cycle earlier.
   assign w_acc_next = {r_acc[W-9:0], key_byte};
   assign w_word_end = (r_j & LOW_MASK) == '0;
   assign w_word_idx = C_LEN'(r_j >> U_LG);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_key_addr <= '0;
         r_j        <= '0;
         r_valid    <= 1'b0;
         r_acc      <= '0;
         r_L_we     <= 1'b0;
         r_L_addr   <= '0;
         r_L_data   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_L_we <= 1'b0;
         r_done <= 1'b0;

         if (r_valid) begin
            r_valid <= 1'b0;
            if (w_word_end) begin
               r_L_we   <= 1'b1;
               r_L_addr <= w_word_idx;
               r_L_data <= w_acc_next;
               r_acc    <= '0;
            end else begin
               r_acc <= w_acc_next;
            end
         end

         // Issue side; the assignments here override the defaults above.
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_acc  <= '0;
                  r_busy <= 1'b1;
                  if (key_len == '0) begin
                     r_state  <= S_ZERO;
                     r_L_we   <= 1'b1;
                     r_L_addr <= '0;
                     r_L_data <= '0;
                  end else begin
                     r_state    <= S_STREAM;
                     r_key_addr <= key_len - B_LEN'(1);
                  end
               end
            end
            S_STREAM: begin
               r_valid <= 1'b1;
               r_j     <= r_key_addr;
               if (r_key_addr == '0) begin
                  r_state <= S_DRAIN;
               end else begin
                  r_key_addr <= r_key_addr - B_LEN'(1);
               end
            end
            S_ZERO: begin
               r_state <= S_FIN;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            S_DRAIN: begin
               // One cycle absorbs byte 0, the next lets the L[0] write land.
               if (!r_valid) begin
                  r_state <= S_FIN;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign key_addr    = r_key_addr;
   assign L_we        = r_L_we;
   assign L_addr      = r_L_addr;
   assign L_data      = r_L_data;
   assign busy        = r_busy;
   assign done        = r_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rc5_key_loader.sv
// Directed bench for rc5_key_loader: a W=32 and a W=16 instance, each fed by a
// synchronous key RAM, with hand-computed L writes and handshake timing.
module tb_rc5_key_loader;

   logic        clk;
   logic        rst;

   logic        start32, start16;
   logic [7:0]  key_len32, key_len16;
   logic [7:0]  kaddr32, kaddr16;
   logic [7:0]  kbyte32, kbyte16;
   logic        we32, we16;
   logic [5:0]  laddr32;
   logic [7:0]  laddr16;
   logic [31:0] ldata32;
   logic [15:0] ldata16;
   logic        busy32, busy16, done32, done16;
   logic [2:0]  dbg32, dbg16;

   logic [7:0]  mem32 [256];
   logic [7:0]  mem16 [256];

   int checks = 0;
   int errors = 0;

   // Observations of one run, indexed by write order / cycle number.
   logic [63:0] obs_addr [64];
   logic [63:0] obs_data [64];
   int          obs_cyc  [64];
   int          n_writes;
   int          done_cyc, done_cnt, busy_first, busy_last, busy_cnt;
   bit          kaddr_changed;
   logic [7:0]  kaddr_at [64];
   logic [63:0] rst_snap;

   rc5_key_loader #(.W(32), .B_LEN(8), .C_LEN(6)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .key_len(key_len32),
      .key_addr(kaddr32), .key_byte(kbyte32), .L_we(we32), .L_addr(laddr32),
      .L_data(ldata32), .busy(busy32), .done(done32), .o_dbg_state(dbg32)
   );

   rc5_key_loader #(.W(16), .B_LEN(8), .C_LEN(8)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .key_len(key_len16),
      .key_addr(kaddr16), .key_byte(kbyte16), .L_we(we16), .L_addr(laddr16),
      .L_data(ldata16), .busy(busy16), .done(done16), .o_dbg_state(dbg16)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      kbyte32 <= mem32[kaddr32];
      kbyte16 <= mem16[kaddr16];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_w(input string tag, input int idx, input logic [63:0] a,
                          input logic [63:0] d, input int cy);
      check({tag, "_addr"}, obs_addr[idx], a);
      check({tag, "_data"}, obs_data[idx], d);
      check({tag, "_cyc"}, 64'(obs_cyc[idx]), 64'(cy));
   endtask

   // Driver: start in cycle 0, then observe cycles 1..ncyc. Extra start pulses
   // in cycles p1/p2, reset pulse in cycle rc (-1 disables each).
   task automatic run(input bit sel16, input int b, input int ncyc,
                      input int p1, input int p2, input int rc);
      logic [7:0] k0;
      n_writes = 0; done_cyc = -1; done_cnt = 0;
      busy_first = -1; busy_last = -1; busy_cnt = 0;
      kaddr_changed = 1'b0; rst_snap = '1;
      for (int i = 0; i < 64; i++) begin
         obs_addr[i] = '0; obs_data[i] = '0; obs_cyc[i] = -1; kaddr_at[i] = '0;
      end
      @(negedge clk);
      k0 = sel16 ? kaddr16 : kaddr32;
      if (sel16) begin start16 = 1'b1; key_len16 = 8'(b); end
      else begin start32 = 1'b1; key_len32 = 8'(b); end
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (c == rc + 1) rst = 1'b1;
         if (sel16 ? we16 : we32) begin
            if (n_writes < 64) begin
               obs_addr[n_writes] = sel16 ? 64'(laddr16) : 64'(laddr32);
               obs_data[n_writes] = sel16 ? 64'(ldata16) : 64'(ldata32);
               obs_cyc[n_writes]  = c;
            end
            n_writes++;
         end
         if (sel16 ? busy16 : busy32) begin
            if (busy_first < 0) busy_first = c;
            busy_last = c;
            busy_cnt++;
         end
         if (sel16 ? done16 : done32) begin
            if (done_cyc < 0) done_cyc = c;
            done_cnt++;
         end
         if (c < 64) kaddr_at[c] = sel16 ? kaddr16 : kaddr32;
         if ((sel16 ? kaddr16 : kaddr32) !== k0) kaddr_changed = 1'b1;
         if (c == rc) begin
            rst = 1'b0;
            #1;
            rst_snap = sel16 ? {kaddr16, we16, laddr16, ldata16, busy16, done16}
                             : {kaddr32, we32, laddr32, ldata32, busy32, done32};
         end
         start32 = 1'b0;
         start16 = 1'b0;
         key_len32 = 8'($urandom_range(0, 255));
         key_len16 = 8'($urandom_range(0, 255));
         if (c == p1 || c == p2) begin
            if (sel16) begin start16 = 1'b1; key_len16 = 8'(b); end
            else begin start32 = 1'b1; key_len32 = 8'(b); end
         end
      end
   endtask

   task automatic check_b16(input string tag);
      check({tag, "_nwr"}, 64'(n_writes), 64'd4);
      check_w({tag, "_w0"}, 0, 64'd3, 64'h0F0E0D0C, 6);
      check_w({tag, "_w1"}, 1, 64'd2, 64'h0B0A0908, 10);
      check_w({tag, "_w2"}, 2, 64'd1, 64'h07060504, 14);
      check_w({tag, "_w3"}, 3, 64'd0, 64'h03020100, 18);
      check({tag, "_done_cyc"}, 64'(done_cyc), 64'd19);
      check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      check({tag, "_busy_first"}, 64'(busy_first), 64'd1);
      check({tag, "_busy_last"}, 64'(busy_last), 64'd18);
      check({tag, "_busy_cnt"}, 64'(busy_cnt), 64'd18);
      check({tag, "_kaddr_c1"}, 64'(kaddr_at[1]), 64'd15);
      check({tag, "_kaddr_c9"}, 64'(kaddr_at[9]), 64'd7);
      check({tag, "_kaddr_c16"}, 64'(kaddr_at[16]), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem32[i] = 8'(i);
         mem16[i] = 8'(8'hA0 + i);
      end
      rst = 1'b0;
      start32 = 1'b0; start16 = 1'b0;
      key_len32 = '0; key_len16 = '0;
      repeat (2) @(negedge clk);

      check("rst_kaddr32", 64'(kaddr32), 64'd0);
      check("rst_we32", 64'(we32), 64'd0);
      check("rst_laddr32", 64'(laddr32), 64'd0);
      check("rst_ldata32", 64'(ldata32), 64'd0);
      check("rst_busy_done32", 64'({busy32, done32}), 64'd0);
      check("rst_all16", {kaddr16, we16, laddr16, ldata16, busy16, done16}, 64'd0);
      rst = 1'b1;

      // b=16 with ignored start pulses in cycles 3 and 19, then a rerun from cycle 20
      run(1'b0, 16, 19, 3, 19, -1);
      check_b16("b16");
      run(1'b0, 16, 22, -1, -1, -1);
      check_b16("b16_rerun");

      // b=10: partial top word
      run(1'b0, 10, 16, -1, -1, -1);
      check("b10_nwr", 64'(n_writes), 64'd3);
      check_w("b10_w0", 0, 64'd2, 64'h00000908, 4);
      check_w("b10_w1", 1, 64'd1, 64'h07060504, 8);
      check_w("b10_w2", 2, 64'd0, 64'h03020100, 12);
      check("b10_done_cyc", 64'(done_cyc), 64'd13);

      // b=0: single zero write, key_addr untouched
      run(1'b0, 0, 6, -1, -1, -1);
      check("b0_nwr", 64'(n_writes), 64'd1);
      check_w("b0_w0", 0, 64'd0, 64'd0, 1);
      check("b0_done_cyc", 64'(done_cyc), 64'd2);
      check("b0_kaddr_moved", 64'(kaddr_changed), 64'd0);

      // W=16, b=5
      run(1'b1, 5, 10, -1, -1, -1);
      check("w16_nwr", 64'(n_writes), 64'd3);
      check_w("w16_w0", 0, 64'd2, 64'h00A4, 3);
      check_w("w16_w1", 1, 64'd1, 64'hA3A2, 5);
      check_w("w16_w2", 2, 64'd0, 64'hA1A0, 7);
      check("w16_done_cyc", 64'(done_cyc), 64'd8);

      // reset in cycle 9 of a b=16 run
      run(1'b0, 16, 14, -1, -1, 9);
      check("rst_mid_outputs", rst_snap, 64'd0);
      check("rst_mid_nwr", 64'(n_writes), 64'd1);
      check_w("rst_mid_w0", 0, 64'd3, 64'h0F0E0D0C, 6);
      check("rst_mid_done_cnt", 64'(done_cnt), 64'd0);
      check("rst_mid_busy_last", 64'(busy_last), 64'd9);

      // clean restart with b=4
      run(1'b0, 4, 10, -1, -1, -1);
      check("b4_nwr", 64'(n_writes), 64'd1);
      check_w("b4_w0", 0, 64'd0, 64'h03020100, 6);
      check("b4_done_cyc", 64'(done_cyc), 64'd7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
